fft_8_bin_serializer: RTL and testbench

- Reader side of the 8-point FFT output interface.
- Tracks each frame through the FFT pipeline and captures the 16 parallel result words (8 real, 8 imaginary) once they are valid.
- Streams the bins one per transfer over a valid/ready interface to the downstream feature-extraction logic, with an |re|+|im| magnitude estimate attached to each bin.

---
 rtl/fft_8_bin_serializer.sv | 133 +++++++++++++
 tb/tb_fft_8_bin_serializer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_8_bin_serializer.sv
// Reader side of the 8-point FFT output: tracks frames through the FFT latency,
// captures the 16 result words and streams bins with an |re|+|im| magnitude.
module fft_8_bin_serializer #(
    parameter int FFT_LATENCY = 3,
    parameter int OUT_BINS    = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_start,
    input  logic [95:0] y_r_bus,
    input  logic [95:0] y_i_bus,
    input  logic        bin_ready,
    output logic        bin_valid,
    output logic [2:0]  bin_index,
    output logic [11:0] bin_real,
    output logic [11:0] bin_imag,
    output logic [12:0] bin_mag,
    output logic        bin_last,
    output logic        busy,
    output logic        frame_drop
);

    localparam int DATA_W = 12;
    localparam logic [2:0] LAST_IDX = 3'(OUT_BINS - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                   state, state_nxt;
    logic [2:0]               idx_p0, idx_nxt;
    logic [FFT_LATENCY-1:0]   fs_dly_p0;
    logic [FFT_LATENCY:0]     fs_shift;
    logic                     tap;
    logic                     capture, drop_nxt, last_acc;
    logic [95:0]              hold_r_p0, hold_i_p0;
    logic [95:0]              src_r, src_i;
    logic signed [DATA_W-1:0] sel_r, sel_i;
    logic [DATA_W:0]          mag_nxt;

    // Magnitude of a 12-bit signed value; 13 bits hold abs(-2048) without saturation.
    function automatic logic [DATA_W:0] abs_ext(input logic signed [DATA_W-1:0] v);
        logic signed [DATA_W:0] w;
        w = {v[DATA_W-1], v};
        if (w < 0) w = -w;
        return w;
    endfunction

    assign fs_shift = {fs_dly_p0, frame_start};
    assign tap      = fs_dly_p0[FFT_LATENCY-1];
    assign last_acc = (state == SEND) && bin_ready && (idx_p0 == LAST_IDX);

    // Stage p0: frame-tracking delay line and control state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fs_dly_p0 <= '0;
            state     <= IDLE;
            idx_p0    <= '0;
        end else begin
            fs_dly_p0 <= fs_shift[FFT_LATENCY-1:0];
            state     <= state_nxt;
            idx_p0    <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx_p0;
        capture   = 1'b0;
        drop_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (tap) begin
                    capture   = 1'b1;
                    state_nxt = SEND;
                    idx_nxt   = '0;
                end
            end
            SEND: begin
                if (bin_ready) begin
                    if (idx_p0 == LAST_IDX) begin
                        idx_nxt = '0;
                        if (tap) capture = 1'b1;
                        else     state_nxt = IDLE;
                    end else begin
                        idx_nxt = idx_p0 + 3'd1;
                    end
                end
                // A frame arriving mid-stream has nowhere to go.
                if (tap && !last_acc) drop_nxt = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A freshly captured frame is read straight off the bus so bin 0 has no bubble.
    always_comb begin
        src_r   = capture ? y_r_bus : hold_r_p0;
        src_i   = capture ? y_i_bus : hold_i_p0;
        sel_r   = '0;
        sel_i   = '0;
        if (state_nxt == SEND) begin
            sel_r = src_r[DATA_W*int'(idx_nxt) +: DATA_W];
            sel_i = src_i[DATA_W*int'(idx_nxt) +: DATA_W];
        end
        mag_nxt = abs_ext(sel_r) + abs_ext(sel_i);
    end

    // Stage p1: holding buffer and registered bin outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_r_p0  <= '0;
            hold_i_p0  <= '0;
            bin_real   <= '0;
            bin_imag   <= '0;
            bin_mag    <= '0;
            frame_drop <= 1'b0;
        end else begin
            if (capture) begin
                hold_r_p0 <= y_r_bus;
                hold_i_p0 <= y_i_bus;
            end
            bin_real   <= sel_r;
            bin_imag   <= sel_i;
            bin_mag    <= mag_nxt;
            frame_drop <= drop_nxt;
        end
    end

    assign bin_valid = (state == SEND);
    assign busy      = (state == SEND);
    assign bin_index = idx_p0;
    assign bin_last  = (state == SEND) && (idx_p0 == LAST_IDX);

endmodule

// File: tb/tb_fft_8_bin_serializer.sv
// Bench for fft_8_bin_serializer: an 8-bin and a 5-bin instance share stimulus and
// are checked every cycle against a frame-level model, plus literal spot checks.
module tb_fft_8_bin_serializer;

    localparam int L = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_start = 1'b0;
    logic        bin_ready = 1'b0;
    logic [95:0] y_r_bus = '0;
    logic [95:0] y_i_bus = '0;

    logic        v[2];
    logic [2:0]  ix[2];
    logic [11:0] re[2];
    logic [11:0] im[2];
    logic [12:0] mg[2];
    logic        lst[2];
    logic        bsy[2];
    logic        drp[2];

    always #5 clk = ~clk;

    fft_8_bin_serializer #(.FFT_LATENCY(L), .OUT_BINS(8)) u8 (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
        .y_r_bus(y_r_bus), .y_i_bus(y_i_bus), .bin_ready(bin_ready),
        .bin_valid(v[0]), .bin_index(ix[0]), .bin_real(re[0]), .bin_imag(im[0]),
        .bin_mag(mg[0]), .bin_last(lst[0]), .busy(bsy[0]), .frame_drop(drp[0])
    );

    fft_8_bin_serializer #(.FFT_LATENCY(L), .OUT_BINS(5)) u5 (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
        .y_r_bus(y_r_bus), .y_i_bus(y_i_bus), .bin_ready(bin_ready),
        .bin_valid(v[1]), .bin_index(ix[1]), .bin_real(re[1]), .bin_imag(im[1]),
        .bin_mag(mg[1]), .bin_last(lst[1]), .busy(bsy[1]), .frame_drop(drp[1])
    );

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 0;

    task automatic check(input string name, input int d, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d t=%0t got=%0d expected=%0d", name, d, $time, got, exp);
        end
    endtask

    function automatic int sx(input logic [95:0] b, input int k);
        logic signed [11:0] t;
        t = b[12*k +: 12];
        return int'(t);
    endfunction

    function automatic int iabs(input int a);
        return (a < 0) ? -a : a;
    endfunction

    // Frame-level model: pending arrival times, one current frame per instance.
    int OB[2] = '{8, 5};
    int cyc = 0;
    int pend[$];
    bit m_act[2];
    int m_idx[2];
    int m_r[2][8];
    int m_i[2][8];
    bit m_drop[2];
    bit arrive, acc, last;

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            pend.delete();
            for (int d = 0; d < 2; d++) begin
                m_act[d] = 0; m_idx[d] = 0; m_drop[d] = 0;
            end
        end else begin
            arrive = 0;
            foreach (pend[j]) if (pend[j] == cyc) arrive = 1;
            while (pend.size() > 0 && pend[0] <= cyc) void'(pend.pop_front());
            if (frame_start) pend.push_back(cyc + L);
            for (int d = 0; d < 2; d++) begin
                acc  = m_act[d] && bin_ready;
                last = acc && (m_idx[d] == OB[d] - 1);
                m_drop[d] = arrive && m_act[d] && !last;
                if (acc) begin
                    if (last) m_act[d] = 0;
                    else      m_idx[d]++;
                end
                if (arrive && !m_act[d]) begin
                    m_act[d] = 1;
                    m_idx[d] = 0;
                    for (int k = 0; k < 8; k++) begin
                        m_r[d][k] = sx(y_r_bus, k);
                        m_i[d][k] = sx(y_i_bus, k);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                int er, ei;
                er = m_act[d] ? m_r[d][m_idx[d]] : 0;
                ei = m_act[d] ? m_i[d][m_idx[d]] : 0;
                check("valid", d, v[d], m_act[d]);
                check("busy", d, bsy[d], m_act[d]);
                check("index", d, ix[d], m_act[d] ? m_idx[d] : 0);
                check("real", d, $signed(re[d]), er);
                check("imag", d, $signed(im[d]), ei);
                check("mag", d, mg[d], iabs(er) + iabs(ei));
                check("last", d, lst[d], m_act[d] && (m_idx[d] == OB[d] - 1));
                check("drop", d, drp[d], m_drop[d]);
            end
        end
    end

    // Logs of accepted indices and drop pulses for the spot checks.
    int acc_log[$];
    int drop_cnt[2] = '{0, 0};
    always @(posedge clk) begin
        if (rst_n) begin
            if (v[0] && bin_ready) acc_log.push_back(int'(ix[0]));
            for (int d = 0; d < 2; d++) if (drp[d]) drop_cnt[d]++;
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_bus_lin();
        for (int k = 0; k < 8; k++) begin
            y_r_bus[12*k +: 12] = 12'(100 * k);
            y_i_bus[12*k +: 12] = 12'(-10 * k);
        end
    endtask

    task automatic rand_bus();
        y_r_bus = {$urandom(), $urandom(), $urandom()};
        y_i_bus = {$urandom(), $urandom(), $urandom()};
    endtask

    task automatic pulse_and_wait(input int n);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        repeat (n - 1) tick();
    endtask

    int base, d0, d1, b0;

    initial begin
        @(posedge clk);
        chk_en = 1;
        repeat (2) tick();
        check("rst_valid", 0, v[0], 0);
        check("rst_mag", 0, mg[0], 0);
        check("rst_drop", 1, drp[1], 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Basic stream
        bin_ready = 1'b1;
        set_bus_lin();
        frame_start = 1'b1;
        for (int t = 1; t <= 3; t++) begin
            tick();
            frame_start = 1'b0;
            check("latency_pre", 0, v[0], 0);
        end
        tick();
        for (int k = 0; k < 8; k++) begin
            check("basic_valid", 0, v[0], 1);
            check("basic_index", 0, ix[0], k);
            check("basic_real", 0, $signed(re[0]), 100 * k);
            check("basic_imag", 0, $signed(im[0]), -10 * k);
            check("basic_mag", 0, mg[0], 110 * k);
            check("basic_last", 0, lst[0], k == 7);
            tick();
        end
        check("basic_end", 0, v[0], 0);
        repeat (2) tick();

        // Back-pressure 1,0,0,...
        base = acc_log.size();
        frame_start = 1'b1;
        for (int t = 0; t < 40; t++) begin
            bin_ready = (t % 3 == 0);
            tick();
            frame_start = 1'b0;
        end
        bin_ready = 1'b1;
        repeat (4) tick();
        check("bp_count", 0, acc_log.size() - base, 8);
        for (int k = 0; k < 8; k++)
            if (base + k < acc_log.size()) check("bp_order", 0, acc_log[base + k], k);

        // Magnitude extremes
        rand_bus();
        y_r_bus[11:0] = 12'h800; y_i_bus[11:0] = 12'h800;
        y_r_bus[23:12] = 12'd2047; y_i_bus[23:12] = 12'd0;
        pulse_and_wait(4);
        check("mag_min", 0, mg[0], 4096);
        check("mag_min", 1, mg[1], 4096);
        tick();
        check("mag_max", 0, mg[0], 2047);
        repeat (10) tick();

        // Back-to-back, 5 cycles apart
        d0 = drop_cnt[0]; d1 = drop_cnt[1];
        set_bus_lin();
        frame_start = 1'b1;
        for (int t = 1; t <= 14; t++) begin
            tick();
            frame_start = (t == 5);
            if (t == 4) begin
                rand_bus();
                b0 = sx(y_r_bus, 0);
            end
            if (t >= 4 && t <= 13) check("b2b_valid", 1, v[1], 1);
            if (t == 6) check("b2b_real", 1, $signed(re[1]), 200);
            if (t == 9) begin
                check("b2b_index", 1, ix[1], 0);
                check("b2b_real0", 1, $signed(re[1]), b0);
            end
        end
        check("b2b_end", 1, v[1], 0);
        check("b2b_nodrop", 1, drop_cnt[1] - d1, 0);
        check("b2b_drop8", 0, drop_cnt[0] - d0, 1);
        repeat (4) tick();

        // Drop, 2 cycles apart
        d0 = drop_cnt[0]; d1 = drop_cnt[1];
        set_bus_lin();
        frame_start = 1'b1;
        for (int t = 1; t <= 14; t++) begin
            tick();
            frame_start = (t == 2);
            if (t == 4) rand_bus();
            if (t == 5) check("drop_real1", 1, $signed(re[1]), 100);
            if (t == 8) check("drop_real4", 1, $signed(re[1]), 400);
        end
        check("drop_once5", 1, drop_cnt[1] - d1, 1);
        check("drop_once8", 0, drop_cnt[0] - d0, 1);
        check("drop_idle", 1, v[1], 0);

        // Reset mid-stream
        set_bus_lin();
        frame_start = 1'b1;
        for (int t = 1; t <= 7; t++) begin
            tick();
            frame_start = (t == 6);
        end
        frame_start = 1'b0;
        check("mid_index", 0, ix[0], 3);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 0, v[0], 0);
        check("arst_index", 0, ix[0], 0);
        check("arst_real", 0, re[0], 0);
        check("arst_mag", 0, mg[0], 0);
        check("arst_busy", 0, bsy[0], 0);
        check("arst_valid", 1, v[1], 0);
        repeat (2) tick();
        rst_n = 1'b1;
        for (int t = 0; t < 8; t++) begin
            tick();
            check("post_rst_quiet", 0, v[0], 0);
        end
        rand_bus();
        b0 = sx(y_r_bus, 0);
        pulse_and_wait(4);
        check("restart_valid", 0, v[0], 1);
        check("restart_index", 0, ix[0], 0);
        check("restart_real", 0, $signed(re[0]), b0);
        repeat (10) tick();

        // Randomized traffic
        for (int t = 0; t < 2000; t++) begin
            frame_start = ($urandom_range(0, 5) == 0);
            bin_ready   = ($urandom_range(0, 9) < 7);
            rand_bus();
            tick();
        end
        frame_start = 1'b0;
        bin_ready   = 1'b1;
        repeat (30) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
